// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: qualifies each frame by the
// low time of rec_readyH, pushes accepted bytes into a FWFT FIFO drained by valid/ready.
module uart_rx_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int MIN_LOW = 64
) (
  input  logic          sys_clk,
  input  logic          sys_rst_l,
  input  logic [7:0]    rec_dataH,
  input  logic          rec_readyH,
  output logic [7:0]    rd_dataH,
  output logic          rd_validH,
  input  logic          rd_readyH,
  output logic [AW:0]   countH,
  output logic          emptyH,
  output logic          fullH,
  output logic          overflowH,
  input  logic          clr_overflowH,
  output logic [7:0]    runt_cntH
);

  typedef enum logic {IDLE, LOW} state_e;

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [7:0]  MIN_LOW_C = 8'(MIN_LOW);

  state_e          state_q, state_d;
  logic            ready_q;
  logic [7:0]      low_cnt_q, low_cnt_d;
  logic [7:0]      runt_cnt_q, runt_cnt_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem [DEPTH];

  logic fall, rise, push, pop, wr_en, drop;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fall       = ready_q & ~rec_readyH;
    rise       = ~ready_q & rec_readyH;
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    runt_cnt_d = runt_cnt_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          low_cnt_d = 8'd1;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = IDLE;
          if (low_cnt_q >= MIN_LOW_C) push = 1'b1;
          else if (runt_cnt_q != 8'hFF) runt_cnt_d = runt_cnt_q + 8'd1;
        end else if (low_cnt_q != 8'hFF) begin
          low_cnt_d = low_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    pop        = rd_validH & rd_readyH;
    wr_en      = push & (~fullH | pop);
    drop       = push & fullH & ~pop;
    wptr_d     = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q;
    if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !wr_en) count_d = count_q - (AW+1)'(1);
    overflow_d = overflow_q;
    if (drop)               overflow_d = 1'b1;
    else if (clr_overflowH) overflow_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      low_cnt_q  <= '0;
      runt_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= rec_readyH;
      low_cnt_q  <= low_cnt_d;
      runt_cnt_q <= runt_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the count, and
  // the empty gating on rd_dataH hides stale contents.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wptr_q] <= rec_dataH;
  end

  assign countH    = count_q;
  assign emptyH    = (count_q == '0);
  assign fullH     = (count_q == DEPTH_C);
  assign rd_validH = ~emptyH;
  assign rd_dataH  = emptyH ? 8'h00 : mem[rptr_q];
  assign overflowH = overflow_q;
  assign runt_cntH = runt_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven on rec_readyH/rec_dataH, accepted
// bytes go into a scoreboard queue and are compared as the host drains the FIFO.
module tb_uart_rx_fifo;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int MIN_LOW = 64;

  logic          sys_clk = 1'b0;
  logic          sys_rst_l = 1'b0;
  logic [7:0]    rec_dataH = 8'h00;
  logic          rec_readyH = 1'b0;
  logic [7:0]    rd_dataH;
  logic          rd_validH;
  logic          rd_readyH = 1'b0;
  logic [AW:0]   countH;
  logic          emptyH, fullH, overflowH;
  logic          clr_overflowH = 1'b0;
  logic [7:0]    runt_cntH;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .MIN_LOW(MIN_LOW)) dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l),
    .rec_dataH(rec_dataH), .rec_readyH(rec_readyH),
    .rd_dataH(rd_dataH), .rd_validH(rd_validH), .rd_readyH(rd_readyH),
    .countH(countH), .emptyH(emptyH), .fullH(fullH),
    .overflowH(overflowH), .clr_overflowH(clr_overflowH), .runt_cntH(runt_cntH)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Low for exactly `low` sampled cycles, then the rise edge; returns one cycle after it.
  task automatic frame(input logic [7:0] b, input int low);
    rec_dataH  = b;
    rec_readyH = 1'b0;
    repeat (low) step();
    rec_readyH = 1'b1;
    step();
    if (low >= MIN_LOW && exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  32'(rd_dataH),  0);
    check({tag, "_valid"}, 32'(rd_validH), 0);
    check({tag, "_count"}, 32'(countH),    0);
    check({tag, "_empty"}, 32'(emptyH),    1);
    check({tag, "_full"},  32'(fullH),     0);
    check({tag, "_ovf"},   32'(overflowH), 0);
    check({tag, "_runt"},  32'(runt_cntH), 0);
  endtask

  // Back-to-back pops, one per cycle, compared against the scoreboard.
  task automatic drain(input string tag);
    int n;
    logic [7:0] e;
    n = exp_q.size();
    rd_readyH = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({tag, "_count"}, 32'(countH), 32'(n - i));
      check({tag, "_data"},  32'(rd_dataH), 32'(e));
      step();
    end
    rd_readyH = 1'b0;
    check({tag, "_empty"}, 32'(emptyH), 1);
    check({tag, "_zero"},  32'(rd_dataH), 0);
  endtask

  initial begin
    // Reset, then rec_readyH low for one cycle and held high: the rise is ignored.
    #2;
    check_reset_vals("rst");
    step();
    sys_rst_l = 1'b1;
    step();
    rec_readyH = 1'b1;
    repeat (5) step();
    check_reset_vals("post_rst");

    // Normal frame, then a single pop.
    frame(8'hA5, 150);
    check("a5_count", 32'(countH), 1);
    check("a5_valid", 32'(rd_validH), 1);
    check("a5_data",  32'(rd_dataH), 32'h A5);
    rd_readyH = 1'b1;
    step();
    rd_readyH = 1'b0;
    check("a5_empty", 32'(emptyH), 1);
    void'(exp_q.pop_front());

    // False starts: 6 and MIN_LOW-1 cycles are runts; exactly MIN_LOW is accepted.
    frame(8'h11, 6);
    check("runt6_count", 32'(countH), 0);
    check("runt6_cnt",   32'(runt_cntH), 1);
    frame(8'h22, MIN_LOW - 1);
    check("runt63_cnt",  32'(runt_cntH), 2);
    frame(8'h3C, MIN_LOW);
    check("min_low_count", 32'(countH), 1);
    check("min_low_runt",  32'(runt_cntH), 2);
    drain("min_low");

    // Fill to full, drop the 17th byte, drain in order, then clear the sticky flag.
    for (int i = 0; i < DEPTH; i++) frame(8'(i), MIN_LOW);
    check("fill_full", 32'(fullH), 1);
    check("fill_ovf",  32'(overflowH), 0);
    frame(8'h10, MIN_LOW);
    check("ovf_set",   32'(overflowH), 1);
    check("ovf_count", 32'(countH), 16);
    drain("ovf_drain");
    check("ovf_sticky", 32'(overflowH), 1);
    clr_overflowH = 1'b1;
    step();
    clr_overflowH = 1'b0;
    check("ovf_clr", 32'(overflowH), 0);

    // Full FIFO, rise coincides with a pop: count holds, no overflow, new byte last.
    for (int i = 0; i < DEPTH; i++) frame(8'h40 + 8'(i), MIN_LOW);
    check("fp_full", 32'(fullH), 1);
    rec_dataH  = 8'h99;
    rec_readyH = 1'b0;
    repeat (MIN_LOW) step();
    check("fp_head", 32'(rd_dataH), 32'(exp_q[0]));
    rec_readyH = 1'b1;
    rd_readyH  = 1'b1;
    step();
    rd_readyH  = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    check("fp_count", 32'(countH), 16);
    check("fp_ovf",   32'(overflowH), 0);
    drain("fp_drain");

    // Reset with 5 buffered bytes and a frame in progress.
    for (int i = 0; i < 5; i++) frame(8'h50 + 8'(i), MIN_LOW);
    check("mid_count", 32'(countH), 5);
    rec_dataH  = 8'h66;
    rec_readyH = 1'b0;
    repeat (20) step();
    #2 sys_rst_l = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    exp_q.delete();
    step();
    sys_rst_l = 1'b1;
    repeat (100) step();
    rec_readyH = 1'b1;
    step();
    check("mid_nopush", 32'(emptyH), 1);
    step();
    frame(8'h77, 80);
    check("mid_next_count", 32'(countH), 1);
    check("mid_next_data",  32'(rd_dataH), 32'h77);
    drain("mid_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver and consumes its byte output (`rec_dataH` / `rec_readyH`). It turns the receiver's level-style ready signal into one push per valid frame and rejects false-start pulses by their low duration. Accepted bytes go into a first-word-fall-through FIFO that the host drains with a valid/ready handshake. Overflow and runt events are reported as status.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256
- `AW`, 4, log2(DEPTH)
- `MIN_LOW`, 64, minimum cycles `rec_readyH` must stay low for the byte to count as a real frame; 1..255
- `sys_clk`  in  1  clock; all logic rises on posedge
- `sys_rst_l`  in  1  reset, asynchronous, active-low
- `rec_dataH`  in  8  received byte from the UART receiver
- `rec_readyH`  in  1  receiver idle/ready level; falls at frame start, rises at frame end
- `rd_dataH`  out  8  head-of-FIFO byte; 0 when empty
- `rd_validH`  out  1  FIFO non-empty
- `rd_readyH`  in  1  host accepts the head byte
- `countH`  out  AW+1  current occupancy, 0..DEPTH
- `emptyH`  out  1  `countH == 0`
- `fullH`  out  1  `countH == DEPTH`
- `overflowH`  out  1  sticky; a valid byte was dropped because the FIFO was full
- `clr_overflowH`  in  1  synchronous clear of `overflowH`
- `runt_cntH`  out  8  saturating count of rejected short low pulses

## Operation
- Edge detector: register `ready_d` (reset 0) samples `rec_readyH` every cycle.
  - Fall = `ready_d & ~rec_readyH`.
  - Rise = `~ready_d & rec_readyH`.
- Qualifier FSM, 2 states:
  - IDLE (reset state): on fall, clear `low_cnt` to 1 and go to LOW. A rise in IDLE is ignored. This covers the receiver's 0→1 transition just after reset.
  - LOW: `low_cnt` increments each cycle and saturates at 255.
    - On rise with `low_cnt >= MIN_LOW`: push `rec_dataH` and go to IDLE.
    - On rise with `low_cnt < MIN_LOW`: increment `runt_cntH` (saturates at 255) with no push, and go to IDLE.
- FIFO: DEPTH×8 memory, with AW-bit read and write pointers that wrap modulo DEPTH and an AW+1-bit count.
  - Pop = `rd_validH & rd_readyH`.
  - Push only: write at `wptr`, `wptr+1`, `count+1`.
  - Pop only: `rptr+1`, `count-1`.
  - Push and pop together: both pointers advance and count is unchanged. This holds even when full; the pop frees the slot, so no overflow.
  - Push while full without pop: byte dropped, pointers and count unchanged, `overflowH` set.
- `overflowH`: set has priority over `clr_overflowH` in the same cycle; otherwise `clr_overflowH` clears it.
- `rd_dataH = emptyH ? 0 : mem[rptr]`. The memory itself is not reset.
- Reset mid-frame or mid-drain:
  - Pointers, count, FSM, `ready_d`, `overflowH` and `runt_cntH` clear immediately.
  - Buffered data is lost.
  - A frame already in progress at reset release is not pushed, because the FSM starts in IDLE.

## Timing
- Reset values: `rd_dataH`=0, `rd_validH`=0, `countH`=0, `emptyH`=1, `fullH`=0, `overflowH`=0, `runt_cntH`=0.
- `low_cnt` counts clock edges in LOW. A `rec_readyH` that is low for exactly N sampled cycles gives `low_cnt` = N at the rise.
- Push latency: the write happens at the clock edge where rise is detected, i.e. the first edge with `rec_readyH`=1 and `ready_d`=0. `rd_validH`, `countH` and `rd_dataH` reflect the byte in the cycle after that edge.
- `rec_dataH` is sampled at that edge. The receiver holds it stable from its last shift until the next frame's eighth bit, so no extra staging is needed.
- Pop: the host sees `rd_dataH` combinationally from the current `rptr`. On the edge with `rd_validH & rd_readyH`, the next entry (or 0 if now empty) appears the following cycle.
- Back-to-back pops at one per cycle are supported. `rd_readyH` with `rd_validH`=0 has no effect.
- Max push rate: one per UART frame, but the FIFO logic itself must tolerate a push every cycle.

## Test plan
- Reset release with `rec_readyH` 0 for 1 cycle then held 1 -> no push, `runt_cntH`=0, `emptyH`=1, `rd_dataH`=0.
- `rec_dataH`=0xA5, `rec_readyH` low 150 cycles then high -> `countH`=1, `rd_validH`=1, `rd_dataH`=0xA5 one cycle after the rise. Pulse `rd_readyH` -> `emptyH`=1 next cycle.
- `rec_readyH` low for 6 cycles (false start) then high -> no push, `runt_cntH`=1. Low for exactly `MIN_LOW`=64 cycles -> pushed.
- 17 valid frames with bytes 0x00..0x10, no reads -> `fullH`=1 after 16, 17th (0x10) dropped, `overflowH`=1. Drain returns 0x00..0x0F in order. `clr_overflowH` then clears `overflowH`.
- FIFO full, rise detected in the same cycle as a pop -> `countH` stays 16, `overflowH` stays 0, new byte read last.
- Reset asserted with `countH`=5 and mid-frame -> all outputs at reset values. The frame completing after release is not pushed, and the next full frame is pushed.
